// File: rtl/fwd_pkg.sv
// Shared types and constants for the ALU operand forwarding control.
// Select codes must match the operand mux input ordering in the datapath.
package fwd_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int SEL_W      = 3;

  localparam logic [SEL_W-1:0] SEL_REGFILE = 3'd0;
  localparam logic [SEL_W-1:0] SEL_EXMEM   = 3'd1;
  localparam logic [SEL_W-1:0] SEL_MEMWB   = 3'd2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic                  rw;
    logic                  mr;
  } stage_t;

endpackage

// File: rtl/fwd_sel_logic.sv
// Priority forwarding compare for one ALU operand.
// The younger EX/MEM producer wins over MEM/WB, and r0 is never forwarded.
module fwd_sel_logic
  import fwd_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  uses,
  input  stage_t                ex_stage,
  input  stage_t                mem_stage,
  output logic [SEL_W-1:0]      sel
);

  logic ex_hit;
  logic mem_hit;

  always_comb begin
    ex_hit  = uses && ex_stage.rw  && (ex_stage.dst  != '0) && (ex_stage.dst  == src);
    mem_hit = uses && mem_stage.rw && (mem_stage.dst != '0) && (mem_stage.dst == src);
    // NOTE: every output gets a default first so no path leaves sel unassigned (no latch).
    sel = SEL_REGFILE;
    if (ex_hit) begin
      sel = SEL_EXMEM;
    end else if (mem_hit) begin
      sel = SEL_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control beside the ID/EX register: tracks
// writers through EX/MEM/WB, drives registered operand selects and the stall.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [REG_ADDR_W-1:0] IdRs,
  input  logic [REG_ADDR_W-1:0] IdRt,
  input  logic                  IdUsesRs,
  input  logic                  IdUsesRt,
  input  logic [REG_ADDR_W-1:0] IdDst,
  input  logic                  IdRegWrite,
  input  logic                  IdMemRead,
  output logic [SEL_W-1:0]      ExSelA,
  output logic [SEL_W-1:0]      ExSelB,
  output logic                  Stall,
  output logic [CNT_W-1:0]      StallCnt
);
  import fwd_pkg::stage_t;
  import fwd_pkg::SEL_REGFILE;

  stage_t           ex_q, ex_d;
  stage_t           mem_q, mem_d;
  // WB stage is kept for debug visibility only; the register file writes
  // before it reads, so no WB forwarding path is needed.
  stage_t           wb_q, wb_d;
  logic [SEL_W-1:0] sel_a_q, sel_a_d;
  logic [SEL_W-1:0] sel_b_q, sel_b_d;
  logic [SEL_W-1:0] raw_sel_a, raw_sel_b;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;

  fwd_sel_logic u_sel_a (
    .src       (IdRs),
    .uses      (IdUsesRs),
    .ex_stage  (ex_q),
    .mem_stage (mem_q),
    .sel       (raw_sel_a)
  );

  fwd_sel_logic u_sel_b (
    .src       (IdRt),
    .uses      (IdUsesRt),
    .ex_stage  (ex_q),
    .mem_stage (mem_q),
    .sel       (raw_sel_b)
  );

  // A load in EX cannot forward its data yet, so a reader in ID must wait a cycle.
  always_comb begin
    stall = ex_q.mr && ex_q.rw && (ex_q.dst != '0) &&
            ((IdUsesRs && (ex_q.dst == IdRs)) || (IdUsesRt && (ex_q.dst == IdRt)));
  end

  always_comb begin
    mem_d   = ex_q;
    wb_d    = mem_q;
    ex_d    = '0;
    sel_a_d = SEL_REGFILE;
    sel_b_d = SEL_REGFILE;
    cnt_d   = cnt_q;
    if (!stall) begin
      ex_d.dst = IdDst;
      ex_d.rw  = IdRegWrite;
      ex_d.mr  = IdMemRead;
      sel_a_d  = raw_sel_a;
      sel_b_d  = raw_sel_b;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (Rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      sel_a_q <= '0;
      sel_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ExSelA   = sel_a_q;
  assign ExSelB   = sel_b_q;
  assign Stall    = stall;
  assign StallCnt = cnt_q;

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Control-side counterpart of the ALU input forwarding muxes in the pipelined SAD datapath. It tracks destination-register information through the EX, MEM and WB stages and produces the registered 3-bit select codes for both ALU operand muxes. It also produces the load-use stall, inserts an EX bubble during a stall, and keeps a saturating stall-cycle counter for performance checks. It sits beside the ID/EX pipeline register, takes decoded ID-stage fields as inputs, and drives the EX-stage mux selects.

Parameters:
REG_ADDR_W, 5, register index width
SEL_W, 3, width of the forwarding select code, matching the operand muxes
CNT_W, 16, width of the stall-cycle counter

Ports:
Clk  in  1  clock; all state updates on the rising edge
Rst  in  1  synchronous, active-high reset
IdRs  in  REG_ADDR_W  source register A of the instruction in ID
IdRt  in  REG_ADDR_W  source register B of the instruction in ID
IdUsesRs  in  1  the ID instruction reads IdRs
IdUsesRt  in  1  the ID instruction reads IdRt
IdDst  in  REG_ADDR_W  destination register of the ID instruction
IdRegWrite  in  1  the ID instruction writes IdDst
IdMemRead  in  1  the ID instruction is a load
ExSelA  out  SEL_W  operand-A mux select, valid during the EX cycle
ExSelB  out  SEL_W  operand-B mux select, valid during the EX cycle
Stall  out  1  hold PC and IF/ID, and bubble ID/EX (combinational)
StallCnt  out  CNT_W  number of stall cycles since reset, saturating

Behaviour:
- Select encoding: 0 = register-file value (normal operation); 1 = EX/MEM ALU result; 2 = MEM/WB writeback value. Codes 3–7 are never driven.
- Internal stage state:
  - EX stage: ex_dst, ex_rw, ex_mr
  - MEM stage: mem_dst, mem_rw, mem_mr
  - WB stage: wb_dst, wb_rw
- Reset (Rst=1 at an edge):
  - all stage fields, ExSelA, ExSelB and StallCnt go to 0
  - Stall therefore reads 0 in the first cycle after reset
  - A reset mid-operation discards all in-flight hazard state. No forwarding is produced until new writers advance.
- Stall (combinational): Stall = ex_mr & ex_rw & (ex_dst != 0) & ((IdUsesRs & ex_dst == IdRs) | (IdUsesRt & ex_dst == IdRt)).
- Each clock edge when not in reset:
  - MEM stage takes the EX fields; WB stage takes the MEM fields. This happens every cycle.
  - If Stall = 0: EX stage takes IdDst, IdRegWrite, IdMemRead.
  - If Stall = 1: EX stage becomes a bubble (ex_rw = 0, ex_mr = 0, ex_dst = 0).
  - If Stall = 0, ExSelA is set as follows:
    - 1 if ex_rw & ex_dst != 0 & ex_dst == IdRs & IdUsesRs
    - else 2 if mem_rw & mem_dst != 0 & mem_dst == IdRs & IdUsesRs
    - else 0
  - ExSelB uses the same rule with IdRt and IdUsesRt.
  - If Stall = 1: ExSelA and ExSelB become 0, since the bubble operands are don't-care.
  - StallCnt increments by 1 when Stall = 1 and holds at 2^CNT_W − 1 once it gets there.
- Priority: when both the EX-stage and MEM-stage producers match, the younger one (code 1) wins.
- Register 0 is never forwarded and never causes a stall.
- No WB-stage forwarding: the register file writes before it reads in the same cycle, so wb_* exists only for debug visibility.
- Latency:
  - Select codes appear one cycle after the dependent instruction is in ID, i.e. during its EX cycle.
  - A load-use dependency costs exactly one stall cycle. On the following cycle the load is in MEM, so the select becomes 2.
- If Rs and Rt name the same register, both selects take the same code.

Decomposition:
- Shared package fwd_pkg holds:
  - the select constants SEL_REGFILE = 0, SEL_EXMEM = 1, SEL_MEMWB = 2
  - REG_ADDR_W
  - a stage-info struct {dst, rw, mr}
- One natural sub-module, fwd_sel_logic: the combinational priority compare for a single operand, instantiated twice (A and B).
- Stage registers, stall logic and the counter stay in the top module.

Test Plan:
- Back-to-back ALU dependency: add r3 written, next instruction reads r3 as Rs -> ExSelA=1, ExSelB=0, Stall=0 throughout.
- Distance-two dependency: r5 written, one independent instruction, then a reader of r5 as Rt -> ExSelB=2 in the reader's EX cycle.
- Load-use: load r7, next instruction reads r7 as Rs -> Stall=1 for exactly one cycle, bubble in EX, then ExSelA=2, StallCnt=1.
- Double match: r4 written twice in consecutive instructions, third reads r4 on both operands -> ExSelA=ExSelB=1.
- r0 writer followed by an r0 reader (including a load to r0) -> selects 0, Stall=0.
- Reset mid-stream: Rst asserted while a load to r2 is in EX and a dependent instruction is in ID -> next cycle Stall=0, selects 0, StallCnt=0. Then force StallCnt to 0xFFFF with a stall -> it stays 0xFFFF.
